// File: rtl/result_uart_tx_if.sv
// result_uart_tx_if: request/result and UART line signals of the result transmitter
//   start      request to send, sampled only while idle
//   data       result word, latched on an accepted start
//   msb_first  0: byte 0 sent first, 1: top byte sent first
//   tx         UART line, idle high
//   busy       frame in progress
//   done       one-cycle pulse after the last stop bit
//   byte_idx   transmission-order index of the byte on the line
interface result_uart_tx_if #(
  parameter int NUM_BYTES = 2
) ();
  logic                       start;
  logic [8*NUM_BYTES-1:0]     data;
  logic                       msb_first;
  logic                       tx;
  logic                       busy;
  logic                       done;
  logic [$clog2(NUM_BYTES):0] byte_idx;
  modport master (output start, data, msb_first, input tx, busy, done, byte_idx);
  modport slave  (input start, data, msb_first, output tx, busy, done, byte_idx);
endinterface

// File: rtl/result_uart_tx.sv
// result_uart_tx: 8N1 UART serialiser for a NUM_BYTES result word
//   clock    system clock, all logic on posedge
//   n_reset  asynchronous active-low reset
//   bus      slave side of result_uart_tx_if (start/data/msb_first in; tx/busy/done/byte_idx out)
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 3958,
  parameter int NUM_BYTES    = 2
) (
  input  logic            clock,
  input  logic            n_reset,
  result_uart_tx_if.slave bus
);
  localparam int DW = 8 * NUM_BYTES;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_BYTES) + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
  state_t          state;
  logic [CW-1:0]   baud;
  logic [2:0]      bit_cnt;
  logic [BW-1:0]   byte_cnt;
  logic [DW-1:0]   shadow;
  logic            msb;
  logic [7:0]      sr;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;
  logic            bit_end;
  logic [BW-1:0]   sel;
  logic [7:0]      cur;
  assign bit_end = baud == CW'(CLKS_PER_BIT - 1);
  // byte position inside the shadow word for the byte about to be sent
  assign sel = msb ? BW'(NUM_BYTES - 1) - byte_cnt : byte_cnt;
  assign cur = 8'(shadow >> {sel, 3'b000});
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shadow   <= '0;
      msb      <= 1'b0;
      sr       <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      baud <= (state == IDLE || state == DONE || bit_end) ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (bus.start) begin
          shadow <= bus.data;
          msb    <= bus.msb_first;
          tx_q   <= 1'b0;
          busy_q <= 1'b1;
          state  <= START;
        end
        START: if (bit_end) begin
          tx_q  <= cur[0];
          sr    <= {1'b0, cur[7:1]};
          state <= DATA;
        end
        DATA: if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            bit_cnt <= '0;
            tx_q    <= 1'b1;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            tx_q    <= sr[0];
            sr      <= sr >> 1;
          end
        end
        STOP: if (bit_end) begin
          if (byte_cnt == BW'(NUM_BYTES - 1)) begin
            byte_cnt <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
            tx_q     <= 1'b0;
            state    <= START;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.byte_idx = byte_cnt;
endmodule
